// File: rtl/efuse_op_sched_if.sv
// eFuse macro pin bundle: strobe controls and address out, read data back.
`timescale 1ns/1ps
interface efuse_op_sched_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              efuse_pgmen;
  logic              efuse_rden;
  logic              efuse_aen;
  logic [ADDR_W-1:0] efuse_addr;
  logic [DATA_W-1:0] efuse_dout;

  modport master (
    output efuse_pgmen,
    output efuse_rden,
    output efuse_aen,
    output efuse_addr,
    input  efuse_dout
  );

  modport slave (
    input  efuse_pgmen,
    input  efuse_rden,
    input  efuse_aen,
    input  efuse_addr,
    output efuse_dout
  );
endinterface

// File: rtl/efuse_op_sched.sv
// Arbitrates the eFuse macro between boot autoload and register-mode accesses
// and sequences the setup / strobe / hold waveform with programmable widths.
`timescale 1ns/1ps
module efuse_op_sched #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int LOAD_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_load_start,
  input  logic              rg_efuse_req,
  input  logic              rg_efuse_op,
  input  logic [ADDR_W-1:0] rg_efuse_addr,
  input  logic              rg_efuse_pgm_en,
  input  logic [3:0]        rg_efuse_tsu,
  input  logic [9:0]        rg_efuse_trd,
  input  logic [9:0]        rg_efuse_tpgm,
  output logic              rg_efuse_ack,
  output logic              rg_efuse_err,
  output logic [DATA_W-1:0] rg_efuse_rdata,
  output logic              rg_efuse_busy,
  efuse_op_sched_if.master  efuse,
  output logic              load_wr_en,
  output logic [ADDR_W-1:0] load_wr_addr,
  output logic [DATA_W-1:0] load_wr_data,
  output logic              boot_load_done
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LOAD_WORDS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_t            state_q, state_n;
  logic [9:0]        cnt_q, cnt_n;
  logic [3:0]        tsu_q, tsu_n;
  logic [9:0]        tw_q, tw_n;
  logic              op_q, op_n;
  logic [ADDR_W-1:0] raddr_q, raddr_n;
  logic              reg_pend_q, reg_pend_n;
  logic              reg_active_q, reg_active_n;
  logic              boot_pend_q, boot_pend_n;
  logic              cur_boot_q, cur_boot_n;
  logic              cur_pgm_q, cur_pgm_n;
  logic [ADDR_W-1:0] load_idx_q, load_idx_n;
  logic [DATA_W-1:0] dcap_q, dcap_n;
  logic              pgmen_q, pgmen_n;
  logic              rden_q, rden_n;
  logic              aen_q, aen_n;
  logic [ADDR_W-1:0] maddr_q, maddr_n;
  logic              ack_q, ack_n;
  logic              err_q, err_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              lwe_q, lwe_n;
  logic [ADDR_W-1:0] lwa_q, lwa_n;
  logic [DATA_W-1:0] lwd_q, lwd_n;
  logic              done_q, done_n;
  logic              busy_q, busy_n;

  logic [3:0] tsu_eff;
  logic [9:0] trd_eff;
  logic [9:0] tpgm_eff;
  logic       boot_accept;
  logic       reg_accept;
  logic       slot_free;

  assign tsu_eff     = (rg_efuse_tsu  == 4'd0)  ? 4'd1  : rg_efuse_tsu;
  assign trd_eff     = (rg_efuse_trd  == 10'd0) ? 10'd1 : rg_efuse_trd;
  assign tpgm_eff    = (rg_efuse_tpgm == 10'd0) ? 10'd1 : rg_efuse_tpgm;
  assign boot_accept = boot_load_start & ~boot_pend_q;
  assign reg_accept  = rg_efuse_req & ~reg_pend_q & ~reg_active_q;
  // The final HOLD cycle doubles as an IDLE slot so back-to-back accesses have no gap.
  assign slot_free   = (state_q == IDLE) | ((state_q == HOLD) & (cnt_q == 10'd0));

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    tsu_n        = tsu_q;
    tw_n         = tw_q;
    op_n         = op_q;
    raddr_n      = raddr_q;
    reg_pend_n   = reg_pend_q;
    reg_active_n = reg_active_q;
    boot_pend_n  = boot_pend_q;
    cur_boot_n   = cur_boot_q;
    cur_pgm_n    = cur_pgm_q;
    load_idx_n   = load_idx_q;
    dcap_n       = dcap_q;
    pgmen_n      = pgmen_q;
    rden_n       = rden_q;
    aen_n        = aen_q;
    maddr_n      = maddr_q;
    ack_n        = 1'b0;
    err_n        = 1'b0;
    rdata_n      = rdata_q;
    lwe_n        = 1'b0;
    lwa_n        = lwa_q;
    lwd_n        = lwd_q;
    done_n       = done_q;

    if (boot_accept) begin
      boot_pend_n = 1'b1;
      done_n      = 1'b0;
    end
    if (reg_accept) begin
      reg_pend_n = 1'b1;
      op_n       = rg_efuse_op;
      raddr_n    = rg_efuse_addr;
    end

    case (state_q)
      SETUP: begin
        if (cnt_q == 10'd0) begin
          state_n = STROBE;
          cnt_n   = tw_q - 10'd1;
          aen_n   = 1'b1;
        end else begin
          cnt_n = cnt_q - 10'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 10'd0) begin
          state_n = HOLD;
          cnt_n   = {6'd0, tsu_q} - 10'd1;
          aen_n   = 1'b0;
          dcap_n  = efuse.efuse_dout;
        end else begin
          cnt_n = cnt_q - 10'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 10'd0) begin
          state_n = IDLE;
          pgmen_n = 1'b0;
          rden_n  = 1'b0;
          if (cur_boot_q) begin
            lwe_n = 1'b1;
            lwa_n = load_idx_q;
            lwd_n = dcap_q;
            if (load_idx_q == LAST_IDX) begin
              boot_pend_n = 1'b0;
              done_n      = 1'b1;
              load_idx_n  = '0;
            end else begin
              load_idx_n = load_idx_q + IDX_ONE;
            end
          end else begin
            reg_active_n = 1'b0;
            ack_n        = 1'b1;
            if (!cur_pgm_q) rdata_n = dcap_q;
          end
        end else begin
          cnt_n = cnt_q - 10'd1;
        end
      end
      default: ;
    endcase

    // Grant: autoload words first, then a pending register access.
    if (slot_free) begin
      if (boot_pend_n) begin
        state_n    = SETUP;
        cur_boot_n = 1'b1;
        cur_pgm_n  = 1'b0;
        rden_n     = 1'b1;
        pgmen_n    = 1'b0;
        aen_n      = 1'b0;
        maddr_n    = load_idx_n;
        tsu_n      = tsu_eff;
        tw_n       = trd_eff;
        cnt_n      = {6'd0, tsu_eff} - 10'd1;
      end else if (reg_pend_n) begin
        reg_pend_n = 1'b0;
        if (op_n && !rg_efuse_pgm_en) begin
          ack_n = 1'b1;
          err_n = 1'b1;
        end else begin
          state_n      = SETUP;
          cur_boot_n   = 1'b0;
          cur_pgm_n    = op_n;
          reg_active_n = 1'b1;
          pgmen_n      = op_n;
          rden_n       = ~op_n;
          aen_n        = 1'b0;
          maddr_n      = raddr_n;
          tsu_n        = tsu_eff;
          tw_n         = op_n ? tpgm_eff : trd_eff;
          cnt_n        = {6'd0, tsu_eff} - 10'd1;
        end
      end
    end

    busy_n = reg_pend_n | reg_active_n;
  end

  // Single register stage for state and every output keeps all pins glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tsu_q        <= '0;
      tw_q         <= '0;
      op_q         <= 1'b0;
      raddr_q      <= '0;
      reg_pend_q   <= 1'b0;
      reg_active_q <= 1'b0;
      boot_pend_q  <= 1'b0;
      cur_boot_q   <= 1'b0;
      cur_pgm_q    <= 1'b0;
      load_idx_q   <= '0;
      dcap_q       <= '0;
      pgmen_q      <= 1'b0;
      rden_q       <= 1'b0;
      aen_q        <= 1'b0;
      maddr_q      <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      lwe_q        <= 1'b0;
      lwa_q        <= '0;
      lwd_q        <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      tsu_q        <= tsu_n;
      tw_q         <= tw_n;
      op_q         <= op_n;
      raddr_q      <= raddr_n;
      reg_pend_q   <= reg_pend_n;
      reg_active_q <= reg_active_n;
      boot_pend_q  <= boot_pend_n;
      cur_boot_q   <= cur_boot_n;
      cur_pgm_q    <= cur_pgm_n;
      load_idx_q   <= load_idx_n;
      dcap_q       <= dcap_n;
      pgmen_q      <= pgmen_n;
      rden_q       <= rden_n;
      aen_q        <= aen_n;
      maddr_q      <= maddr_n;
      ack_q        <= ack_n;
      err_q        <= err_n;
      rdata_q      <= rdata_n;
      lwe_q        <= lwe_n;
      lwa_q        <= lwa_n;
      lwd_q        <= lwd_n;
      done_q       <= done_n;
      busy_q       <= busy_n;
    end
  end

  assign efuse.efuse_pgmen = pgmen_q;
  assign efuse.efuse_rden  = rden_q;
  assign efuse.efuse_aen   = aen_q;
  assign efuse.efuse_addr  = maddr_q;
  assign rg_efuse_ack      = ack_q;
  assign rg_efuse_err      = err_q;
  assign rg_efuse_rdata    = rdata_q;
  assign rg_efuse_busy     = busy_q;
  assign load_wr_en        = lwe_q;
  assign load_wr_addr      = lwa_q;
  assign load_wr_data      = lwd_q;
  assign boot_load_done    = done_q;

endmodule
